// File: rtl/slon_pkg.sv
// rtl/slon_pkg.sv - shared SLON link constants, checker state and data word type
//
// Purpose: definitions shared by the SLON generator and the slon_rx receiver.
//   DOUT_WIDTH   : width of one link data word
//   CLK_FACTOR   : nominal system clocks per upstream strobe period
//   slon_state_e : sequence checker state (ACQ, LOCKED)
//   slon_word_t  : one link data word
package slon_pkg;

  localparam int DOUT_WIDTH = 8;
  localparam int CLK_FACTOR = 10;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } slon_state_e;

  typedef logic [DOUT_WIDTH-1:0] slon_word_t;

endpackage

// File: rtl/slon_rx_fifo.sv
// rtl/slon_rx_fifo.sv - first-word-fall-through output buffer for slon_rx
//
// Purpose: small synchronous FWFT FIFO; the head word is visible on rd_data
// whenever empty is low. A write into a full FIFO is accepted only when a read
// happens in the same cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  : write request and word
//   rd_en           : pop the head word (ignored when empty)
//   rd_data         : head word, 0 when empty
//   full, empty     : occupancy flags
module slon_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_rd;
  logic w_wr;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_rd    = rd_en & ~w_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_wr    = wr_en & (~w_full | w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full    = w_full;
  assign empty   = w_empty;

endmodule

// File: rtl/slon_rx.sv
// rtl/slon_rx.sv - SLON receiver: strobe synchronizer, capture, sequence checker, output buffer
//
// Purpose: samples an asynchronous strobe/data pair from the upstream SLON
// generator, captures one word per strobe falling edge, checks that words form
// an incrementing sequence and buffers captured words for a ready/valid consumer.
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   rx_clk, rx_data      : upstream strobe and data (asynchronous to clk)
//   out_data, out_valid  : head word of the output buffer and its valid flag
//   out_ready            : consumer accepts the head word when out_valid is high
//   locked               : sequence checker is LOCKED
//   err_cnt              : sequence errors while LOCKED, saturating
//   word_cnt             : words captured since reset, wrapping
//   ovf                  : sticky, a captured word was dropped on a full buffer
module slon_rx #(
  parameter int DOUT_WIDTH = slon_pkg::DOUT_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_clk,
  input  logic [DOUT_WIDTH-1:0] rx_data,
  output logic [DOUT_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic [15:0]           err_cnt,
  output logic [31:0]           word_cnt,
  output logic                  ovf
);

  import slon_pkg::*;

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  // Synchronizers; r_clk_s3 is the previous synchronized strobe value.
  logic                  r_clk_s1;
  logic                  r_clk_s2;
  logic                  r_clk_s3;
  logic [DOUT_WIDTH-1:0] r_dat_s1;
  logic [DOUT_WIDTH-1:0] r_dat_s2;

  // Registered capture event and word, one cycle after the edge is seen.
  logic                  r_cap;
  logic [DOUT_WIDTH-1:0] r_word;

  slon_state_e           r_state;
  logic                  r_locked;
  logic [DOUT_WIDTH-1:0] r_exp;
  logic [RUN_W-1:0]      r_run;
  logic                  r_miss;
  logic [15:0]           r_err;
  logic [31:0]           r_wcnt;
  logic                  r_ovf;

  logic                  w_fall;
  logic                  w_match;
  logic [RUN_W-1:0]      w_run_next;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd;
  logic                  w_drop;

  assign w_fall     = r_clk_s3 & ~r_clk_s2;
  assign w_match    = (r_word == r_exp);
  assign w_run_next = w_match ? (r_run + RUN_W'(1)) : RUN_W'(1);
  assign w_rd       = ~w_empty & out_ready;
  assign w_drop     = r_cap & w_full & ~w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_dat_s1 <= '0;
      r_dat_s2 <= '0;
      r_cap    <= 1'b0;
      r_word   <= '0;
    end else begin
      r_clk_s1 <= rx_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= rx_data;
      r_dat_s2 <= r_dat_s1;
      // Falling strobe edge: data has been stable for the whole high phase.
      r_cap    <= w_fall;
      r_word   <= r_dat_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ACQ;
      r_locked <= 1'b0;
      r_exp    <= '0;
      r_run    <= '0;
      r_miss   <= 1'b0;
      r_err    <= '0;
      r_wcnt   <= '0;
      r_ovf    <= 1'b0;
    end else if (r_cap) begin
      r_wcnt <= r_wcnt + 32'd1;
      r_exp  <= r_word + DOUT_WIDTH'(1);
      if (w_drop) r_ovf <= 1'b1;
      case (r_state)
        ACQ: begin
          r_run <= w_run_next;
          if (w_run_next >= RUN_W'(LOCK_COUNT)) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
            r_miss   <= 1'b0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            r_miss <= 1'b0;
          end else begin
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (r_miss) begin
              // Second mismatch in a row: this word starts a new run.
              r_state  <= ACQ;
              r_locked <= 1'b0;
              r_run    <= RUN_W'(1);
              r_miss   <= 1'b0;
            end else begin
              r_miss <= 1'b1;
            end
          end
        end
        default: r_state <= ACQ;
      endcase
    end
  end

  slon_rx_fifo #(
    .WIDTH (DOUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_cap),
    .wr_data (r_word),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign out_valid = ~w_empty;
  assign locked    = r_locked;
  assign err_cnt   = r_err;
  assign word_cnt  = r_wcnt;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_slon_rx.sv
// tb/tb_slon_rx.sv - directed self-checking bench for slon_rx
module tb_slon_rx;

  import slon_pkg::*;

  localparam int HALF = CLK_FACTOR / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_clk;
  slon_word_t  rx_data;
  slon_word_t  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  slon_word_t rx_q[$];

  always #5 clk = ~clk;

  slon_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx_clk    (rx_clk),
    .rx_data   (rx_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt),
    .ovf       (ovf)
  );

  // Inputs change at posedge+1, so a handshake seen here completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rx_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input slon_word_t w);
    rx_data = w;
    rx_clk  = 1'b1;
    tick(HALF);
    rx_clk  = 1'b0;
    tick(HALF);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic chk_q(input string tag, input int idx, input logic [31:0] exp);
    chk(tag, (idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'hDEAD, exp);
  endtask

  initial begin
    rst       = 1'b1;
    rx_clk    = 1'b0;
    rx_data   = '0;
    out_ready = 1'b1;
    tick(3);
    rst = 1'b0;

    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_locked", 32'(locked),   0);
    chk("rst_err",   32'(err_cnt),   0);
    chk("rst_wcnt",  word_cnt,       0);
    chk("rst_ovf",   32'(ovf),       0);

    // Latency of the first word, counted from the edge that samples rx_clk low.
    rx_data = 8'h00;
    rx_clk  = 1'b1;
    tick(HALF);
    rx_clk  = 1'b0;
    tick(1); chk("lat_e1", 32'(out_valid), 0);
    tick(1); chk("lat_e2", 32'(out_valid), 0);
    tick(1); chk("lat_e3", 32'(out_valid), 0);
    tick(1); chk("lat_e4", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 0);
    tick(HALF - 4);

    send_word(8'h01);
    send_word(8'h02);
    chk("acq_after2", 32'(locked), 0);
    send_word(8'h03);
    chk("lock_on3", 32'(locked), 1);
    send_word(8'h04);
    chk("seq_err", 32'(err_cnt), 0);
    chk("seq_wcnt", word_cnt, 5);
    chk("seq_qlen", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk_q("seq_q", i, i);

    // Single replaced word: one error, lock kept.
    send_word(8'h09);
    send_word(8'h0A);
    send_word(8'h0B);
    chk("one_err", 32'(err_cnt), 1);
    chk("one_lock", 32'(locked), 1);

    // Two misses in a row drop lock; a fresh run of four relocks.
    send_word(8'h11);
    chk("miss1_err", 32'(err_cnt), 2);
    chk("miss1_lock", 32'(locked), 1);
    send_word(8'h1E);
    chk("miss2_err", 32'(err_cnt), 3);
    chk("miss2_lock", 32'(locked), 0);
    send_word(8'h1F);
    send_word(8'h20);
    chk("relock_pre", 32'(locked), 0);
    send_word(8'h21);
    chk("relock", 32'(locked), 1);
    chk("relock_err", 32'(err_cnt), 3);
    chk("relock_wcnt", word_cnt, 13);

    // Wrap of the expected value through FF -> 00.
    pulse_rst();
    send_word(8'hFD);
    send_word(8'hFE);
    send_word(8'hFF);
    chk("wrap_pre", 32'(locked), 0);
    send_word(8'h00);
    chk("wrap_lock", 32'(locked), 1);
    send_word(8'h01);
    chk("wrap_err", 32'(err_cnt), 0);
    chk("wrap_locked", 32'(locked), 1);
    chk("wrap_wcnt", word_cnt, 5);

    // Overflow: six captures into a four-word buffer with no reads.
    out_ready = 1'b0;
    tick(2);
    rx_q.delete();
    for (int i = 0; i < 6; i++) send_word(slon_word_t'(8'h40 + i));
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_valid", 32'(out_valid), 1);
    chk("ovf_head", 32'(out_data), 8'h40);
    chk("ovf_wcnt", word_cnt, 11);
    out_ready = 1'b1;
    tick(8);
    chk("ovf_drained", 32'(out_valid), 0);
    chk("ovf_qlen", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_q("ovf_q", i, 8'h40 + i);
    chk("ovf_sticky", 32'(ovf), 1);

    // Full buffer: a read in the capture cycle lets the new word in.
    rx_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(slon_word_t'(8'h50 + i));
    rx_data = 8'h54;
    rx_clk  = 1'b1;
    tick(HALF);
    rx_clk  = 1'b0;
    tick(3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(HALF - 4);
    out_ready = 1'b1;
    tick(8);
    chk("full_rw_qlen", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk_q("full_rw_q", i, 8'h50 + i);

    // Reset with words buffered and the checker locked.
    pulse_rst();
    out_ready = 1'b1;
    send_word(8'h00);
    out_ready = 1'b0;
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    chk("pre_rst_lock", 32'(locked), 1);
    chk("pre_rst_head", 32'(out_data), 8'h01);
    pulse_rst();
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_lock", 32'(locked), 0);
    chk("post_rst_wcnt", word_cnt, 0);
    chk("post_rst_err", 32'(err_cnt), 0);
    chk("post_rst_ovf", 32'(ovf), 0);
    rx_data = 8'h77;
    tick(10);
    chk("no_cap_low", word_cnt, 0);
    chk("no_cap_valid", 32'(out_valid), 0);
    send_word(8'h07);
    chk("resume_wcnt", word_cnt, 1);
    chk("resume_data", 32'(out_data), 8'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
